// File: rtl/cnn_conv_pkg.sv
// cnn_conv_pkg: shared widths, config FSM states and arithmetic helpers for the convolution engine
package cnn_conv_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_WINDOW_SIZE = 9;
    localparam int DEF_OUT_CH = 4;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // element index of the weight for channel c, tap t in a flat weight vector
    function automatic int w_slot(input int c, input int t, input int taps);
        return c * taps + t;
    endfunction

    // lowest bit of element idx in a vector of w-bit elements
    function automatic int lo_bit(input int idx, input int w);
        return idx * w;
    endfunction

    // arithmetic shift, saturate to a dw-bit signed range, then optionally clamp negatives
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] a, input int sh,
                                                     input int dw, input logic relu);
        logic signed [63:0] y, hi, lo;
        y = a >>> sh;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        y = y > hi ? hi : y < lo ? lo : y;
        return relu && y < 0 ? 64'sd0 : y;
    endfunction
endpackage

// File: rtl/cnn_conv_tap.sv
// cnn_conv_tap: one MAC stage across all output channels, with its own input skew line
module cnn_conv_tap
    import cnn_conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_CH = DEF_OUT_CH,
    parameter int IDX = 0
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     en,
    input  logic                     v_in,
    input  logic [DATA_W-1:0]        x_in,
    input  logic [OUT_CH*DATA_W-1:0] w,
    input  logic [OUT_CH*ACC_W-1:0]  acc_in,
    output logic                     v_out,
    output logic [OUT_CH*ACC_W-1:0]  acc_out
);
    logic [DATA_W-1:0] x;
    logic signed [2*DATA_W-1:0] p;
    logic [OUT_CH*ACC_W-1:0] acc_d;

    if (IDX == 0) begin : g_direct
        assign x = x_in;
    end else begin : g_skew
        localparam int SKW = IDX * DATA_W;
        logic [SKW-1:0] sk;
        // delay the raw tap IDX cycles so it meets the partial sum arriving from upstream
        always_ff @(posedge clk)
            if (!stall) sk <= SKW'({sk, x_in});
        assign x = sk[SKW-1 -: DATA_W];
    end

    // multiply-accumulate every channel; taps beyond the active count contribute nothing
    always_comb begin
        p = '0;
        acc_d = acc_in;
        for (int c = 0; c < OUT_CH; c++) begin
            p = $signed(x) * $signed(w[lo_bit(c, DATA_W) +: DATA_W]);
            acc_d[lo_bit(c, ACC_W) +: ACC_W] = acc_in[lo_bit(c, ACC_W) +: ACC_W] + (en ? ACC_W'(p) : '0);
        end
    end

    // advance the stage unless the output is stalled; reset discards the beat
    always_ff @(posedge clk)
        if (rst) v_out <= 1'b0;
        else if (!stall) begin
            v_out <= v_in;
            acc_out <= acc_d;
        end
endmodule

// File: rtl/cnn_conv_array.sv
// cnn_conv_array: systolic multi-channel convolution with bias, shift, saturation and ReLU
module cnn_conv_array
    import cnn_conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int OUT_CH = DEF_OUT_CH,
    localparam int TAPS_W = $clog2(WINDOW_SIZE + 1),
    localparam int SHIFT_W = $clog2(ACC_W)
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_load,
    input  logic [TAPS_W-1:0]                   cfg_taps,
    input  logic [SHIFT_W-1:0]                  cfg_shift,
    input  logic                                cfg_relu,
    input  logic [OUT_CH*WINDOW_SIZE*DATA_W-1:0] weight,
    input  logic [OUT_CH*ACC_W-1:0]             bias,
    output logic                                cfg_busy,
    output logic                                cfg_err,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WINDOW_SIZE*DATA_W-1:0]       in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_CH*DATA_W-1:0]            out_data,
    output logic [31:0]                         out_cnt
);
    logic stall, accept, nxt_busy, in_v_q, relu_q;
    logic [0:0] st;
    logic [TAPS_W-1:0] taps_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [OUT_CH*WINDOW_SIZE*DATA_W-1:0] w_q;
    logic [OUT_CH*ACC_W-1:0] b_q;
    logic [WINDOW_SIZE*DATA_W-1:0] in_q;
    logic [WINDOW_SIZE:0] v;
    logic [WINDOW_SIZE:0][OUT_CH*ACC_W-1:0] acc;
    logic [OUT_CH*DATA_W-1:0] pp;

    assign stall = out_valid & ~out_ready;
    assign in_ready = ~stall & ~cfg_load;
    assign accept = in_valid & in_ready;
    assign cfg_busy = st == ST_BUSY;
    assign nxt_busy = stall | accept | (|v);
    assign v[0] = in_v_q;
    assign acc[0] = b_q;

    for (genvar t = 0; t < WINDOW_SIZE; t++) begin : g_tap
        logic [OUT_CH*DATA_W-1:0] wt;
        for (genvar c = 0; c < OUT_CH; c++) begin : g_w
            assign wt[lo_bit(c, DATA_W) +: DATA_W] = w_q[lo_bit(w_slot(c, t, WINDOW_SIZE), DATA_W) +: DATA_W];
        end
        cnn_conv_tap #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_CH(OUT_CH), .IDX(t)) u_tap (
            .clk(clk),
            .rst(rst),
            .stall(stall),
            .en(int'(taps_q) > t),
            .v_in(v[t]),
            .x_in(in_q[lo_bit(t, DATA_W) +: DATA_W]),
            .w(wt),
            .acc_in(acc[t]),
            .v_out(v[t+1]),
            .acc_out(acc[t+1])
        );
    end

    // shift, saturate and clamp each channel's finished sum
    always_comb begin
        pp = '0;
        for (int c = 0; c < OUT_CH; c++)
            pp[lo_bit(c, DATA_W) +: DATA_W] = DATA_W'(sat_shift(64'($signed(acc[WINDOW_SIZE][lo_bit(c, ACC_W) +: ACC_W])),
                                                                int'(shift_q), DATA_W, relu_q));
    end

    // capture an accepted window; the register holds along with the rest of the pipeline
    always_ff @(posedge clk)
        if (rst) in_v_q <= 1'b0;
        else if (!stall) begin
            in_v_q <= accept;
            if (accept) in_q <= in_data;
        end

    // register the post-processed results and hold them while the consumer stalls
    always_ff @(posedge clk)
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
        end else if (!stall) begin
            out_valid <= v[WINDOW_SIZE];
            if (v[WINDOW_SIZE]) out_data <= pp;
        end

    // config FSM: busy while any beat is in flight; loads are taken only when idle
    always_ff @(posedge clk)
        if (rst) begin
            st <= ST_IDLE;
            cfg_err <= 1'b0;
            taps_q <= TAPS_W'(WINDOW_SIZE);
            shift_q <= '0;
            relu_q <= 1'b0;
            w_q <= '0;
            b_q <= '0;
        end else begin
            st <= nxt_busy ? ST_BUSY : ST_IDLE;
            cfg_err <= cfg_load & cfg_busy;
            if (cfg_load & ~cfg_busy) begin
                taps_q <= cfg_taps;
                shift_q <= cfg_shift;
                relu_q <= cfg_relu;
                w_q <= weight;
                b_q <= bias;
            end
        end

    // count completed output handshakes
    always_ff @(posedge clk)
        if (rst) out_cnt <= '0;
        else if (out_valid & out_ready) out_cnt <= out_cnt + 32'd1;
endmodule

// File: tb/tb_cnn_conv_array.sv
// tb_cnn_conv_array: scoreboard bench for the convolution engine
module tb_cnn_conv_array;
    localparam int DW = 16, AW = 32, WS = 9, OC = 4;

    logic clk = 1'b0, rst = 1'b1, cfg_load = 1'b0, cfg_relu = 1'b0, in_valid = 1'b0, out_ready = 1'b1, bp_en = 1'b0;
    logic in_ready, out_valid, cfg_busy, cfg_err;
    logic [3:0] cfg_taps = 4'd9;
    logic [4:0] cfg_shift = '0;
    logic [OC*WS*DW-1:0] weight = '0;
    logic [OC*AW-1:0] bias = '0;
    logic [WS*DW-1:0] in_data = '0;
    logic [OC*DW-1:0] out_data;
    logic [31:0] out_cnt;
    logic [63:0] sb[$];
    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    cnn_conv_array #(.DATA_W(DW), .ACC_W(AW), .WINDOW_SIZE(WS), .OUT_CH(OC)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_taps(cfg_taps), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .weight(weight), .bias(bias), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WS*DW-1:0] win_seq(input int base);
        logic [WS*DW-1:0] r;
        for (int t = 0; t < WS; t++) r[t*DW +: DW] = 16'(base + t);
        return r;
    endfunction

    function automatic logic [OC*WS*DW-1:0] w_diag(input logic [15:0] val);
        logic [OC*WS*DW-1:0] r = '0;
        for (int c = 0; c < OC; c++) r[(c*WS+c)*DW +: DW] = val;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input logic [OC*WS*DW-1:0] w, input logic [OC*AW-1:0] b,
                        input logic [3:0] taps, input logic [4:0] sh, input logic relu);
        weight = w; bias = b; cfg_taps = taps; cfg_shift = sh; cfg_relu = relu; cfg_load = 1'b1;
        @(posedge clk);
        #1 cfg_load = 1'b0;
    endtask

    task automatic send(input logic [WS*DW-1:0] win, input logic [63:0] exp);
        int n = 0;
        in_valid = 1'b1;
        in_data = win;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: in_ready stuck at %b, wanted 1", in_ready);
        end else begin
            acc_cyc = cyc + 1;
            sb.push_back(exp);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, wanted 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got %h with no expected entry", out_data);
                end else chk("out_data", 64'(out_data), sb.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data = 64'(out_data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        logic [OC*AW-1:0] bp_bias;
        logic [63:0] e;
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        load(w_diag(16'd1), '0, 4'd9, 5'd0, 1'b0);
        send(win_seq(1), 64'h0004_0003_0002_0001);
        chk("busy_in_flight", 64'(cfg_busy), 64'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(cyc - acc_cyc), 64'd10);
        drain();

        load({OC*WS{16'h7fff}}, '0, 4'd9, 5'd0, 1'b0);
        send({WS{16'h7fff}}, {OC{16'h7fff}});
        send({WS{16'h8001}}, {OC{16'h8000}});
        drain();
        load({OC*WS{16'h7fff}}, '0, 4'd9, 5'd0, 1'b1);
        send({WS{16'h8001}}, 64'h0);
        send({WS{16'h7fff}}, {OC{16'h7fff}});
        drain();

        load(w_diag(16'd1), '0, 4'd9, 5'd0, 1'b0);
        send(win_seq(1), 64'h0004_0003_0002_0001);
        load({OC*WS{16'd2}}, {OC{32'd8}}, 4'd4, 5'd2, 1'b0);
        chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
        @(posedge clk);
        #1 chk("cfg_err_clears", 64'(cfg_err), 64'd0);
        send(win_seq(11), 64'h000e_000d_000c_000b);
        drain();
        load({OC*WS{16'd2}}, {OC{32'd8}}, 4'd4, 5'd2, 1'b0);
        chk("cfg_err_idle", 64'(cfg_err), 64'd0);
        send({WS{16'd3}}, {OC{16'd8}});
        send(win_seq(1), {OC{16'd7}});
        drain();

        load(w_diag(16'd1), '0, 4'd9, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) send(win_seq(i * 10 + 1), 64'h0);
        do_reset();
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("valid_after_rst", 64'(seen), 64'd0);
        chk("cnt_after_rst", 64'(out_cnt), 64'd0);
        chk("busy_after_rst", 64'(cfg_busy), 64'd0);
        @(posedge clk);
        #1 send(win_seq(1), 64'h0);
        drain();

        do_reset();
        for (int c = 0; c < OC; c++) bp_bias[c*AW +: AW] = 32'(c * 100);
        load(w_diag(16'd2), bp_bias, 4'd9, 5'd0, 1'b0);
        bp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < OC; c++) e[c*DW +: DW] = 16'(2 * (i * 10 + 1 + c) + 100 * c);
            send(win_seq(i * 10 + 1), e);
        end
        drain();
        bp_en = 1'b0;
        chk("out_cnt", 64'(out_cnt), 64'd20);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_conv_array.md
# cnn_conv_array

Parametrised systolic convolution engine, the next-generation replacement for the fixed-size 32-bit convolution stage. Each accepted beat carries one pre-windowed input vector of `WINDOW_SIZE` samples. The engine computes `OUT_CH` dot products against weights latched at configuration time, and adds per-channel bias, shift, saturation and optional ReLU. It sits between the window generator and the pooling/writeback stage, with ready/valid on both sides. All channel results for a window leave together, deskewed.

## Interface
- `DATA_W`, 16: signed sample, weight and output width.
- `ACC_W`, 32: signed accumulator and bias width; must be ≥ 2·`DATA_W`.
- `WINDOW_SIZE`, 9: taps per window (pipeline MAC stages).
- `OUT_CH`, 4: output channels computed in parallel.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `cfg_load`, in, 1: latch `cfg_*`, `weight` and `bias` into internal registers.
- `cfg_taps`, in, clog2(`WINDOW_SIZE`+1): active taps; taps with index ≥ `cfg_taps` use weight 0.
- `cfg_shift`, in, clog2(`ACC_W`): arithmetic right shift applied before saturation.
- `cfg_relu`, in, 1: clamp negative outputs to 0.
- `weight`, in, `OUT_CH`·`WINDOW_SIZE`·`DATA_W`: weight for channel c, tap t at slice (c·`WINDOW_SIZE`+t)·`DATA_W`.
- `bias`, in, `OUT_CH`·`ACC_W`: per-channel bias.
- `cfg_busy`, out, 1: any valid beat in the pipeline.
- `cfg_err`, out, 1: one-cycle pulse when `cfg_load` is rejected.
- `in_valid`, in, 1 / `in_ready`, out, 1 / `in_data`, in, `WINDOW_SIZE`·`DATA_W`: window input; tap t at slice t·`DATA_W`.
- `out_valid`, out, 1 / `out_ready`, in, 1 / `out_data`, out, `OUT_CH`·`DATA_W`: results, channel c at slice c·`DATA_W`.
- `out_cnt`, out, 32: count of completed output handshakes; wraps.

## Operation
**Configuration**
- `cfg_load` is accepted only when `cfg_busy`=0. Otherwise it is ignored and `cfg_err` pulses the next cycle.
- Reset values: `cfg_taps`=`WINDOW_SIZE`, `cfg_shift`=0, `cfg_relu`=0, weights=0, bias=0.

**Stage structure**
- Stage 0 computes acc = bias[c] + in_data[0]·w[c][0].
- Stage t adds in_data[t]·w[c][t] to the accumulator. Input taps are delayed t cycles by a per-tap skew register.
- Products are signed `DATA_W`×`DATA_W`, sign-extended to `ACC_W`. Accumulation wraps modulo 2^`ACC_W`; no overflow detection.

**Post-process** (final stage, per channel)
- y = acc >>> `cfg_shift`.
- Saturate y to [−2^(`DATA_W`−1), 2^(`DATA_W`−1)−1].
- If `cfg_relu`=1 and y<0, y=0.

**Flow control**
- A valid bit travels with each stage. Bubbles propagate; data under valid=0 is don't-care.
- stall = `out_valid` & ~`out_ready`. While stall is high, every stage register, skew register and valid bit holds.
- `in_ready` = ~stall & ~`cfg_load`. When `cfg_load` and `in_valid` occur in the same cycle, `cfg_load` wins and the beat is not taken.
- `out_cnt` increments on each `out_valid`&`out_ready`.

**Reset** (mid-operation included)
- Clears all valid bits, `out_valid`=0, `out_data`=0, `out_cnt`=0, `cfg_err`=0 and all config to its reset values.
- In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge e produces `out_valid`=1 after edge e+`WINDOW_SIZE`+1, provided there are no stalls.
- Throughput: one beat per cycle with `out_ready` held at 1.
- `out_data` and `out_valid` are registered and stable while stalled. `in_ready` is combinational from `out_ready`, `out_valid` and `cfg_load`.
- `cfg_busy` is registered: the OR of all stage valid bits.
- Config takes effect for beats accepted from the cycle after the `cfg_load` edge.

## Structure
- Package `cnn_conv_pkg`:
  - default widths;
  - a `sat_shift` function (shift, saturate, relu);
  - slice-index helper functions.
- Sub-module `cnn_conv_tap`: one stage for all `OUT_CH` channels. It holds the accumulator registers, the skewed input taps, the valid bit and the hold-on-stall logic.
- The top level instantiates `WINDOW_SIZE` taps plus the post-process and output register, the config FSM (idle accept / busy reject) and `out_cnt`.

## Test plan
- **Identity:** `WINDOW_SIZE`=9, `OUT_CH`=4; w[c][c]=1, others 0, bias 0, shift 0; window = 1..9. Expect `out_data` = {4,3,2,1} (channel 3..0), exactly 10 cycles after acceptance.
- **Saturation and ReLU:** all weights 0x7FFF, window all 0x7FFF, shift 0. Expect every channel = 0x7FFF. Repeat with window all 0x8001 and `cfg_relu`=1; expect 0.
- **Taps and shift:** `cfg_taps`=4, all weights 2, window all 3, bias 8, shift 2. Acc = 4·6+8 = 32, so every channel outputs 8.
- **Backpressure:** stream 20 beats with `out_ready` toggling randomly. Outputs match the model in order, with no loss or duplication; `out_cnt`=20; `out_data` holds while stalled.
- **Config while busy:** `cfg_load` while a beat is in flight. The load is ignored, `cfg_err` pulses once, and the old weights are used. A load after drain is accepted.
- **Reset mid-stream:** assert `rst` with 5 beats in flight. `out_valid` stays 0 afterwards, `out_cnt`=0 and config returns to its reset values.
